// File: rtl/world.sv
// Super Mario world core: Mario position/jump physics against a built-in level, camera, and pixel lookup.
// Define HOLD_JUMP_EN to end a jump early when the jump button is released.
module world #(
  parameter int TICK_BIT = 18,
  parameter int WORLD_W  = 4096,
  parameter int JUMP_H   = 96
) (
  input  logic [31:0] clkdiv_i,
  input  logic        rstn_i,
  input  logic        jump_i,
  input  logic        left_i,
  input  logic        right_i,
  input  logic [8:0]  row_addr_i,
  input  logic [9:0]  col_addr_i,
  output logic [5:0]  type_o,
  output logic [10:0] h_o,
  output logic [10:0] w_o,
  output logic [12:0] mario_x_o,
  output logic [12:0] mario_y_o,
  output logic [1:0]  jump_state_o,
  output logic        bounds_o
);

  // state   | meaning
  // GROUND  | standing on a solid tile
  // RISING  | jump in progress, moving up 2 px per tick
  // FALLING | airborne, moving down 2 px per tick
  typedef enum logic [1:0] {GROUND = 2'd0, RISING = 2'd1, FALLING = 2'd2} js_e;

  localparam logic [12:0] X_MAX   = 13'(WORLD_W - 32);
  localparam logic [12:0] CAM_MAX = 13'(WORLD_W - 640);
  localparam logic [12:0] JUMP_HL = 13'(JUMP_H);

  logic        tick_q;
  logic [12:0] x_q, x_d, y_q, y_d, takeoff_q, takeoff_d;
  js_e         js_q, js_d;
  logic        tick, rise_stop;
  logic [12:0] x_mv, nx, ny, probe;
  logic [12:0] cam_x, wx, ry;
  logic        unused_clkdiv;

  assign unused_clkdiv = ^clkdiv_i;

  function automatic logic [2:0] map_type(input logic [12:0] px, input logic [12:0] py);
    logic [7:0] tx, ty;
    tx = px[12:5];
    ty = py[12:5];
    map_type = 3'd0;
    if (ty == 8'd13 || ty == 8'd14)                              map_type = 3'd1;
    else if (ty == 8'd9 && tx >= 8'd10 && tx <= 8'd12)           map_type = 3'd2;
    else if (ty == 8'd9 && tx == 8'd16)                          map_type = 3'd3;
    else if ((ty == 8'd11 || ty == 8'd12) && (tx == 8'd24 || tx == 8'd25)) map_type = 3'd4;
    else if (ty == 8'd5 && tx >= 8'd30 && tx <= 8'd33)           map_type = 3'd2;
  endfunction

  function automatic logic solid(input logic [12:0] px, input logic [12:0] py);
    solid = (map_type(px, py) != 3'd0);
  endfunction

`ifdef HOLD_JUMP_EN
  assign rise_stop = ~jump_i;
`else
  assign rise_stop = 1'b0;
`endif

  assign tick = clkdiv_i[TICK_BIT] & ~tick_q;

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    js_d      = js_q;
    takeoff_d = takeoff_q;
    x_mv      = x_q;
    nx        = x_q;
    ny        = y_q;
    probe     = y_q;
    if (tick) begin
      if (right_i && !left_i && x_q != X_MAX) begin
        nx = x_q + 13'd1;
        if (!solid(nx + 13'd31, y_q) && !solid(nx + 13'd31, y_q + 13'd31)) x_mv = nx;
      end else if (left_i && !right_i && x_q != 13'd0) begin
        nx = x_q - 13'd1;
        if (!solid(nx, y_q) && !solid(nx, y_q + 13'd31)) x_mv = nx;
      end
      x_d = x_mv;
      unique case (js_q)
        GROUND: begin
          probe = y_q + 13'd32;
          if (jump_i) begin
            takeoff_d = y_q;
            js_d      = RISING;
          end else if (!solid(x_mv, probe) && !solid(x_mv + 13'd31, probe)) begin
            js_d = FALLING;
          end
        end
        RISING: begin
          if (rise_stop) begin
            js_d = FALLING;
          end else begin
            ny    = (y_q >= 13'd2) ? y_q - 13'd2 : 13'd0;
            probe = ny - 13'd1;
            // Touching a ceiling counts as a hit: the pixel row just above Mario is solid.
            if (solid(x_mv, probe) || solid(x_mv + 13'd31, probe)) begin
              y_d  = {probe[12:5], 5'd0} + 13'd32;
              js_d = FALLING;
            end else begin
              y_d = ny;
              if (takeoff_q - ny >= JUMP_HL) js_d = FALLING;
            end
          end
        end
        FALLING: begin
          ny    = y_q + 13'd2;
          probe = ny + 13'd32;
          if (solid(x_mv, probe) || solid(x_mv + 13'd31, probe)) begin
            y_d  = {probe[12:5], 5'd0} - 13'd32;
            js_d = GROUND;
          end else begin
            y_d = ny;
          end
        end
        default: js_d = GROUND;
      endcase
    end
  end

  always_ff @(posedge clkdiv_i[0]) begin
    if (rstn_i) begin
      tick_q    <= 1'b0;
      x_q       <= 13'd64;
      y_q       <= 13'd384;
      js_q      <= GROUND;
      takeoff_q <= 13'd384;
    end else begin
      tick_q    <= clkdiv_i[TICK_BIT];
      x_q       <= x_d;
      y_q       <= y_d;
      js_q      <= js_d;
      takeoff_q <= takeoff_d;
    end
  end

  always_comb begin
    cam_x = 13'd0;
    if (x_q >= 13'd304) cam_x = (x_q - 13'd304 > CAM_MAX) ? CAM_MAX : x_q - 13'd304;
  end

  assign wx = cam_x + {3'b000, col_addr_i};
  assign ry = {4'b0000, row_addr_i};

  always_comb begin
    type_o = 6'd0;
    h_o    = 11'd0;
    w_o    = 11'd0;
    if (row_addr_i < 9'd480 && col_addr_i < 10'd640) begin
      if (ry >= y_q && ry < y_q + 13'd32 && wx >= x_q && wx < x_q + 13'd32) begin
        type_o = 6'd5;
        h_o    = 11'(ry - y_q);
        w_o    = 11'(wx - x_q);
      end else begin
        type_o = {3'b000, map_type(wx, ry)};
        h_o    = {6'b0, row_addr_i[4:0]};
        w_o    = {6'b0, wx[4:0]};
      end
    end
  end

  assign mario_x_o    = x_q;
  assign mario_y_o    = y_q;
  assign jump_state_o = js_q;
  assign bounds_o     = (x_q == 13'd0) || (x_q == X_MAX);

endmodule

// File: tb/tb_world.sv
// Bench for world: position scoreboard driven per tick, pixel lookup table, reset-mid-jump sequence.
module tb_world;

  logic [31:0] clkdiv = '0;
  logic        rstn, jump, left, right;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic [5:0]  type_w;
  logic [10:0] h, w;
  logic [12:0] mario_x, mario_y;
  logic [1:0]  jump_state;
  logic        bounds;

  int vecs = 0;
  int errs = 0;

  always #5 clkdiv = clkdiv + 32'd1;

  world #(.TICK_BIT(2), .WORLD_W(4096), .JUMP_H(96)) dut (
    .clkdiv_i(clkdiv), .rstn_i(rstn), .jump_i(jump), .left_i(left), .right_i(right),
    .row_addr_i(row_addr), .col_addr_i(col_addr),
    .type_o(type_w), .h_o(h), .w_o(w),
    .mario_x_o(mario_x), .mario_y_o(mario_y), .jump_state_o(jump_state), .bounds_o(bounds)
  );

  typedef struct {
    string       name;
    logic [12:0] x, y;
    logic [1:0]  js;
    logic        b;
  } pos_t;

  typedef struct {
    string       name;
    logic [8:0]  row;
    logic [9:0]  col;
    logic [5:0]  t;
    logic [10:0] h, w;
  } pix_t;

  pos_t pos_q[$];
  pix_t pix_q[$];

  // The DUT ticks on the clkdiv[0] rising edge where clkdiv[2:0] becomes 3'b101.
  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clkdiv[0]); while (clkdiv[2:0] != 3'b101);
    end
    #1;
  endtask

  task automatic check_pos();
    pos_t e;
    e = pos_q.pop_front();
    vecs++;
    if (mario_x !== e.x || mario_y !== e.y || jump_state !== e.js || bounds !== e.b) begin
      errs++;
      $display("FAIL %s: got x=%0d y=%0d js=%0d b=%0d, want x=%0d y=%0d js=%0d b=%0d",
               e.name, mario_x, mario_y, jump_state, bounds, e.x, e.y, e.js, e.b);
    end
  endtask

  task automatic run_ticks(input string name, input logic l, input logic r, input logic j,
                           input int n, input int ex, input int ey, input int ejs, input int eb);
    pos_t e;
    left = l; right = r; jump = j;
    e.name = name; e.x = 13'(ex); e.y = 13'(ey); e.js = 2'(ejs); e.b = 1'(eb);
    pos_q.push_back(e);
    tick_wait(n);
    left = 0; right = 0; jump = 0;
    check_pos();
  endtask

  task automatic run_pix(input pix_t v);
    pix_t e;
    row_addr = v.row; col_addr = v.col;
    pix_q.push_back(v);
    #1;
    e = pix_q.pop_front();
    vecs++;
    if (type_w !== e.t || h !== e.h || w !== e.w) begin
      errs++;
      $display("FAIL %s: got type=%0d h=%0d w=%0d, want type=%0d h=%0d w=%0d",
               e.name, type_w, h, w, e.t, e.h, e.w);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vecs);
    $fatal(1);
  end

  initial begin
    pix_t tbl0[8];
    pix_t tbl1[4];
    pos_t e;

    tbl0[0] = '{"ground",    9'd420, 10'd100, 6'd1, 11'd4,  11'd4};
    tbl0[1] = '{"brick",     9'd300, 10'd330, 6'd2, 11'd12, 11'd10};
    tbl0[2] = '{"mario",     9'd390, 10'd70,  6'd5, 11'd6,  11'd6};
    tbl0[3] = '{"sky",       9'd100, 10'd5,   6'd0, 11'd4,  11'd5};
    tbl0[4] = '{"qblock",    9'd290, 10'd520, 6'd3, 11'd2,  11'd8};
    tbl0[5] = '{"mario_br",  9'd415, 10'd95,  6'd5, 11'd31, 11'd31};
    tbl0[6] = '{"row_oob",   9'd480, 10'd10,  6'd0, 11'd0,  11'd0};
    tbl0[7] = '{"col_oob",   9'd10,  10'd640, 6'd0, 11'd0,  11'd0};
    tbl1[0] = '{"cam_mario", 9'd384, 10'd304, 6'd5, 11'd0,  11'd0};
    tbl1[1] = '{"cam_pipe",  9'd360, 10'd372, 6'd4, 11'd8,  11'd0};
    tbl1[2] = '{"pipe_stop", 9'd360, 10'd340, 6'd4, 11'd8,  11'd4};
    tbl1[3] = '{"mario_cam", 9'd415, 10'd335, 6'd5, 11'd31, 11'd31};

    rstn = 1; jump = 0; left = 0; right = 0; row_addr = '0; col_addr = '0;
    repeat (3) @(posedge clkdiv[0]);
    do @(posedge clkdiv[0]); while (clkdiv[2:0] != 3'b001);
    #1 rstn = 0;

    e.name = "reset"; e.x = 13'd64; e.y = 13'd384; e.js = 2'd0; e.b = 1'b0;
    pos_q.push_back(e);
    check_pos();

    run_ticks("left64",    1, 0, 0, 64, 0,  384, 0, 1);
    run_ticks("left_hold", 1, 0, 0, 6,  0,  384, 0, 1);
    run_ticks("right10",   0, 1, 0, 10, 10, 384, 0, 0);
    run_ticks("right64",   0, 1, 0, 54, 64, 384, 0, 0);

    for (int i = 0; i < 8; i++) run_pix(tbl0[i]);

    run_ticks("jump_pulse", 0, 0, 1, 1,  64, 384, 1, 0);
    run_ticks("rise_top",   0, 0, 0, 48, 64, 288, 2, 0);
    run_ticks("fall_mid",   0, 0, 0, 24, 64, 336, 2, 0);
    run_ticks("land",       0, 0, 0, 24, 64, 384, 0, 0);

    run_ticks("walk330",     0, 1, 0, 266, 330, 384, 0, 0);
    run_ticks("jump330",     0, 0, 1, 1,   330, 384, 1, 0);
    run_ticks("ceiling",     0, 0, 0, 32,  330, 320, 2, 0);
    run_ticks("land330",     0, 0, 0, 32,  330, 384, 0, 0);

    run_ticks("walk700", 0, 1, 0, 370, 700, 384, 0, 0);
    run_pix(tbl1[0]);
    run_pix(tbl1[1]);
    run_ticks("pipe", 0, 1, 0, 60, 736, 384, 0, 0);
    run_pix(tbl1[2]);
    run_pix(tbl1[3]);

    run_ticks("jump736",  0, 0, 1, 1,  736, 384, 1, 0);
    run_ticks("rise10",   0, 0, 0, 10, 736, 364, 1, 0);
    rstn = 1;
    @(posedge clkdiv[0]);
    #1;
    e.name = "reset_midjump"; e.x = 13'd64; e.y = 13'd384; e.js = 2'd0; e.b = 1'b0;
    pos_q.push_back(e);
    check_pos();
    do @(posedge clkdiv[0]); while (clkdiv[2:0] != 3'b001);
    #1 rstn = 0;

    run_ticks("hold_rejump", 0, 0, 1, 98, 64, 384, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/world.md
Name: world

Overview:
- Game-world core for the Super Mario VGA design: holds Mario's world position and jump state.
- Applies walking, jumping and gravity against a fixed built-in level, and scrolls a 640x480 camera that follows Mario.
- For each VGA pixel address it returns the object type plus the pixel's row (h) and column (w) offset inside that object, for the sprite/tile renderer.

Parameters:
- TICK_BIT, 18: clkdiv bit whose rising edge is the physics tick.
- WORLD_W, 4096: world width in pixels (multiple of 32, at least 640).
- JUMP_H, 96: maximum rise in pixels above the take-off Y.

Ports:
- clkdiv input 32: free-running divider bus from the clock divider; clkdiv[0] is the single clock, all state is on posedge clkdiv[0], and other bits are sampled only as data.
- rstn input 1: synchronous reset, active-high despite its name.
- jump input 1: jump button, level.
- left input 1: walk-left button, level.
- right input 1: walk-right button, level.
- row_addr input 9: VGA pixel row, 0..479.
- col_addr input 10: VGA pixel column, 0..639.
- type output 6: object at the pixel; 0 sky, 1 ground, 2 brick, 3 question block, 4 pipe, 5 Mario.
- h output 11: pixel row offset inside the object, zero-extended.
- w output 11: pixel column offset inside the object, zero-extended.
- mario_x output 13: world X of Mario's left edge.
- mario_y output 13: world Y of Mario's top edge (Y grows downward).
- jump_state output 2: 0 GROUND, 1 RISING, 2 FALLING.
- bounds output 1: 1 while mario_x==0 or mario_x==WORLD_W-32.

Behaviour:
- Reset values: mario_x=64, mario_y=384, jump_state=0, bounds=0, tick-edge register=0.
- Tick: one-cycle pulse when clkdiv[TICK_BIT] is 1 and its registered copy is 0. Nothing moves between ticks.
- Mario is a 32x32 box. The world is tiled in 32x32 tiles; tile(px,py) = (px>>5, py>>5).
- Solid tiles (all non-sky types are solid):
  - Rows 13-14 (y 416..479), every column: ground.
  - Row 9, tile cols 10-12: brick.
  - Row 9, col 16: question block.
  - Rows 11-12, cols 24-25: pipe.
  - Row 5, cols 30-33: brick.
- Horizontal, on each tick:
  - right only: x+1. left only: x-1. Both or neither: no move.
  - The move is rejected if the leading-edge column hits a solid tile at Mario's top or bottom row (y or y+31).
  - X is clamped to 0..WORLD_W-32.
- Vertical, on each tick, evaluated after the horizontal move:
  - GROUND, jump=1: record take-off Y, go to RISING.
  - GROUND, no solid tile under either bottom corner at y+32: go to FALLING.
  - RISING: y-2. If either top corner enters a solid tile, snap y to that tile's bottom (tile_row*32+32) and go to FALLING. If take-off Y minus y reaches JUMP_H, go to FALLING.
  - FALLING: y+2. If either bottom corner enters a solid tile, snap y to tile_row*32-32 and go to GROUND.
  - Holding jump re-jumps on the first GROUND tick after landing.
- Camera: cam_x = mario_x-304, clamped to 0..WORLD_W-640.
- Pixel lookup is combinational on row_addr, col_addr and current state (latency 0). With wx = cam_x+col_addr:
  - Inside Mario's box: type 5, h = row_addr-mario_y, w = wx-mario_x.
  - Otherwise: the map type at tile(wx,row_addr), h = row_addr[4:0], w = wx[4:0]. Sky is type 0 with the same offsets.
  - row_addr≥480 or col_addr≥640: type 0, h=0, w=0.
- Reset mid-jump returns every register to its reset value on the next clock.

Optional Feature:
- HOLD_JUMP_EN defined: releasing jump while RISING ends the rise on the next tick and goes to FALLING, giving variable jump height.
- Undefined: the rise always continues to JUMP_H or a ceiling, regardless of the jump input.

Test Plan:
- Reset (TICK_BIT=2 override), then release → mario_x=64, mario_y=384, jump_state=0, bounds=0.
- Hold left 70 ticks → mario_x falls to 0 after 64 ticks and stays 0, bounds=1. Then right for 10 ticks → mario_x=10, bounds=0.
- From x=64, one-tick jump pulse → jump_state=1. After 48 ticks mario_y=288 and jump_state=2. After 48 more ticks mario_y=384 and jump_state=0.
- With mario_x=330, jump → mario_y reaches 320 after 32 ticks, snaps there, jump_state=2, then lands back at 384.
- With mario_x=700, hold right → stops at mario_x=736 against the pipe. bounds stays 0.
- With mario_x=64 (cam_x=0):
  - row 420, col 100 → type 1, h=4, w=4.
  - row 300, col 330 → type 2, h=12, w=10.
  - row 390, col 70 → type 5, h=6, w=6.
  - row 100, col 5 → type 0.
